// File: rtl/nav_pkg.sv
// Shared types and default timing for the vacuum-robot navigation controller.
package nav_pkg;

  typedef enum logic [2:0] {
    S_DESLIGADO = 3'd0,
    S_PARADO    = 3'd1,
    S_FRENTE    = 3'd2,
    S_GIRA_ESQ  = 3'd3,
    S_GIRA_DIR  = 3'd4,
    S_RECUO     = 3'd5,
    S_ERRO      = 3'd6,
    S_BAT_BAIXA = 3'd7
  } state_t;

  localparam int DEB_CYCLES_DEF  = 4;
  localparam int TURN_CYCLES_DEF = 8;

endpackage

// File: rtl/filtro_entrada.sv
// One-bit input conditioner: two-flop synchroniser followed by a debounce counter.
module filtro_entrada #(
  parameter int   DEB_CYCLES = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q, filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      filt_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      // Any cycle agreeing with the filtered value restarts the stability window.
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout_o = filt_q;

endmodule

// File: rtl/controle_navegacao.sv
// Navigation controller: filters the button/battery/obstacle inputs and runs the
// Moore motion FSM with its timed turn/reverse counter.
module controle_navegacao
  import nav_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       botao,
  input  logic       bateria,
  input  logic       F,
  input  logic       T,
  input  logic       LE,
  input  logic       LD,
  output logic       Frente,
  output logic       RotL,
  output logic       RotR,
  output logic       Atras,
  output logic       ERRO,
  output logic       ligado,
  output logic [2:0] estado
);

  localparam int TW = $clog2(TURN_CYCLES + 1);

  logic [5:0] raw_in, filt;
  assign raw_in = {LD, LE, T, F, bateria, botao};

  // Battery filter resets to "OK" so power-up never flags a low battery.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_filt
      filtro_entrada #(
        .DEB_CYCLES(DEB_CYCLES),
        .RESET_VAL ((gi == 1) ? 1'b1 : 1'b0)
      ) u_filt (
        .clk   (clk),
        .rst   (rst),
        .din_i (raw_in[gi]),
        .dout_o(filt[gi])
      );
    end
  endgenerate

  logic botao_f, bateria_f, f_f, t_f, le_f, ld_f;
  assign {ld_f, le_f, t_f, f_f, bateria_f, botao_f} = filt;

  state_t          state_q, state_d;
  logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
  logic            turn_done, in_turn;

  assign turn_done = (turn_cnt_q == TW'(TURN_CYCLES - 1));
  assign in_turn   = (state_q == S_GIRA_ESQ) || (state_q == S_GIRA_DIR) ||
                     (state_q == S_RECUO);

  always_comb begin
    state_d = state_q;
    if (!botao_f) begin
      state_d = S_DESLIGADO;
    end else if (!bateria_f && (state_q != S_DESLIGADO)) begin
      state_d = S_BAT_BAIXA;
    end else begin
      case (state_q)
        S_DESLIGADO: if (bateria_f) state_d = S_PARADO;
        S_PARADO: begin
          if (!f_f)       state_d = S_FRENTE;
          else if (!le_f) state_d = S_GIRA_ESQ;
          else if (!ld_f) state_d = S_GIRA_DIR;
          else if (!t_f)  state_d = S_RECUO;
          else            state_d = S_ERRO;
        end
        S_FRENTE:               if (f_f) state_d = S_PARADO;
        S_GIRA_ESQ, S_GIRA_DIR: if (turn_done) state_d = S_PARADO;
        S_RECUO:                if (turn_done) state_d = S_GIRA_DIR;
        default:                state_d = state_q;
      endcase
    end

    // Counter restarts on every state entry and only runs inside timed states.
    if (state_d != state_q)  turn_cnt_d = '0;
    else if (in_turn)        turn_cnt_d = turn_cnt_q + 1'b1;
    else                     turn_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DESLIGADO;
      turn_cnt_q <= '0;
      Frente     <= 1'b0;
      RotL       <= 1'b0;
      RotR       <= 1'b0;
      Atras      <= 1'b0;
      ERRO       <= 1'b0;
      ligado     <= 1'b0;
      estado     <= 3'd0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      Frente     <= (state_d == S_FRENTE);
      RotL       <= (state_d == S_GIRA_ESQ);
      RotR       <= (state_d == S_GIRA_DIR);
      Atras      <= (state_d == S_RECUO);
      ERRO       <= (state_d == S_ERRO);
      ligado     <= (state_d != S_DESLIGADO);
      estado     <= state_d;
    end
  end

endmodule

// File: tb/tb_controle_navegacao.sv
// Scoreboard bench: stimulus pushes expected outputs from a behavioural model,
// a monitor pops and compares them every cycle.
module tb_controle_navegacao;

  localparam int DEB  = 4;
  localparam int TURN = 8;

  logic clk = 1'b0;
  logic rst, botao, bateria, F, T, LE, LD;
  logic Frente, RotL, RotR, Atras, ERRO, ligado;
  logic [2:0] estado;

  always #5 clk = ~clk;

  controle_navegacao #(.DEB_CYCLES(DEB), .TURN_CYCLES(TURN)) dut (
    .clk(clk), .rst(rst), .botao(botao), .bateria(bateria),
    .F(F), .T(T), .LE(LE), .LD(LD),
    .Frente(Frente), .RotL(RotL), .RotR(RotR), .Atras(Atras),
    .ERRO(ERRO), .ligado(ligado), .estado(estado)
  );

  typedef struct packed {
    logic [2:0] estado;
    logic ligado, erro, atras, rotr, rotl, frente;
  } out_t;

  out_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Pending input values, applied on the next falling edge.
  logic rst_v = 1'b1, botao_v = 1'b0, bateria_v = 1'b1;
  logic f_v = 1'b0, t_v = 1'b0, le_v = 1'b0, ld_v = 1'b0;

  // Reference model: filtered value flips once the last DEB synchronised
  // samples all disagree with it; states follow the priority rules directly.
  bit [5:0] hist[$];
  bit [5:0] mf;
  int ms = 0;
  int entry = 0;
  int edge_n = 0;

  task automatic model_edge();
    bit [5:0] r;
    int ns;
    int n;
    bit all_diff;
    out_t e;
    r = {LD, LE, T, F, bateria, botao};
    edge_n++;
    if (rst) begin
      ms = 0;
      entry = edge_n;
      mf = 6'b000010;
      hist.delete();
      for (int i = 0; i <= DEB; i++) hist.push_back(6'b000010);
    end else begin
      if (!mf[0]) ns = 0;
      else if (!mf[1] && ms != 0) ns = 7;
      else begin
        case (ms)
          0: ns = mf[1] ? 1 : 0;
          1: ns = !mf[2] ? 2 : !mf[4] ? 3 : !mf[5] ? 4 : !mf[3] ? 5 : 6;
          2: ns = mf[2] ? 1 : 2;
          3, 4: ns = (edge_n - entry >= TURN) ? 1 : ms;
          5: ns = (edge_n - entry >= TURN) ? 4 : 5;
          default: ns = ms;
        endcase
      end
      if (ns != ms) entry = edge_n;
      ms = ns;
      n = hist.size();
      for (int b = 0; b < 6; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (hist[n-2-k][b] == mf[b]) all_diff = 1'b0;
        if (all_diff) mf[b] = ~mf[b];
      end
      hist.push_back(r);
      if (hist.size() > DEB + 2) void'(hist.pop_front());
    end
    e.estado = ms[2:0];
    e.ligado = (ms != 0);
    e.erro   = (ms == 6);
    e.atras  = (ms == 5);
    e.rotr   = (ms == 4);
    e.rotl   = (ms == 3);
    e.frente = (ms == 2);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = rst_v; botao = botao_v; bateria = bateria_v;
      F = f_v; T = t_v; LE = le_v; LD = ld_v;
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic set_in(input logic b, input logic bat, input logic f,
                        input logic le, input logic ld, input logic t);
    botao_v = b; bateria_v = bat; f_v = f; le_v = le; ld_v = ld; t_v = t;
  endtask

  // Monitor: outputs are registered, so one expectation per cycle.
  initial begin
    out_t e;
    out_t a;
    int mon_n;
    mon_n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {estado, ligado, ERRO, Atras, RotR, RotL, Frente};
        mon_n++;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs edge=%0d actual estado=%0d ligado/erro/atras/rotr/rotl/frente=%b required estado=%0d flags=%b",
                   mon_n, a.estado, a[5:0], e.estado, e[5:0]);
        end
      end
    end
  end

  initial begin
    int lat;
    bit found;
    int hold;
    rst = 1'b1; botao = 1'b0; bateria = 1'b1; F = 1'b0; T = 1'b0; LE = 1'b0; LD = 1'b0;

    run(2);
    rst_v = 1'b0;
    set_in(1, 1, 0, 0, 0, 0);
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      run(1);
      #1;
      lat = k;
      if (ligado === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || lat != 3 + DEB) begin
      failures++;
      $display("FAIL power_on_latency actual=%0d edges (found=%0d) required=%0d", lat, found, 3 + DEB);
    end
    $display("txn power_on latency=%0d", lat);
    run(5);

    set_in(1, 1, 1, 0, 0, 0); run(3);
    set_in(1, 1, 0, 0, 0, 0); run(6);
    $display("txn front_glitch");
    set_in(1, 1, 1, 0, 0, 0); run(14);
    set_in(1, 1, 0, 0, 0, 0); run(20);
    $display("txn rotate_left");
    set_in(1, 1, 1, 1, 0, 0); run(16);
    $display("txn rotate_right");
    set_in(1, 1, 1, 1, 1, 0); run(26);
    $display("txn reverse_escape");
    set_in(1, 1, 1, 1, 1, 1); run(12);
    set_in(1, 1, 0, 0, 0, 0); run(10);
    set_in(0, 1, 0, 0, 0, 0); run(10);
    $display("txn trapped_error");
    set_in(1, 1, 1, 0, 0, 0); run(12);
    set_in(1, 0, 1, 0, 0, 0); run(10);
    set_in(1, 1, 0, 0, 0, 0); run(8);
    set_in(0, 0, 0, 0, 0, 0); run(10);
    $display("txn low_battery");
    set_in(1, 1, 1, 1, 1, 0); run(16);
    rst_v = 1'b1; run(1); rst_v = 1'b0;
    run(14);
    $display("txn reset_mid_reverse");

    for (int s = 0; s < 260; s++) begin
      botao_v   = ($urandom_range(15) != 0);
      bateria_v = ($urandom_range(15) != 0);
      f_v  = ($urandom_range(2) == 0);
      le_v = ($urandom_range(1) == 0);
      ld_v = ($urandom_range(1) == 0);
      t_v  = ($urandom_range(1) == 0);
      hold = $urandom_range(14, 1);
      if ($urandom_range(63) == 0) begin
        rst_v = 1'b1; run(1); rst_v = 1'b0;
      end
      run(hold);
      $display("txn random seg=%0d b=%0b bat=%0b F=%0b LE=%0b LD=%0b T=%0b hold=%0d",
               s, botao_v, bateria_v, f_v, le_v, ld_v, t_v, hold);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain actual_pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
